// File: rtl/world_city_sched.sv
// City-index controller: manual step, timed auto-scan and post-press hold-off, with change strobe and blank window.
// Latency: a button edge or dwell expiry updates CITY_SEL on the sampling edge; inputs are sampled every cycle, so there is no backpressure.
module world_city_sched #(
  parameter int N_CITY    = 4,
  parameter int DWELL     = 5,
  parameter int HOLD      = 10,
  parameter int BLANK_CYC = 2
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       SEC_TICK,
  input  logic       BTN_NEXT,
  input  logic       BTN_MODE,
  output logic [2:0] CITY_SEL,
  output logic       AUTO,
  output logic       HOLD_ACT,
  output logic       SEL_CHG,
  output logic       BLANK
);

  localparam int MAXC = (DWELL > HOLD) ? DWELL : HOLD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW   = $clog2(BLANK_CYC + 1);

  typedef enum logic [1:0] {MANUAL, AUTO_RUN, AUTO_HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
  logic [2:0]      city_q, city_d;
  logic            nxt_q, nxt_d;
  logic            mode_q, mode_d;
  logic            auto_q, auto_d;
  logic            hold_act_q, hold_act_d;
  logic            sel_chg_q, sel_chg_d;
  logic            blank_q, blank_d;
  logic            nxt_edge, mode_edge, adv;

  // Previous levels reset high so a button held through reset must be released first.
  assign nxt_edge  = BTN_NEXT & ~nxt_q;
  assign mode_edge = BTN_MODE & ~mode_q;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    hold_d  = hold_q;
    adv     = 1'b0;
    nxt_d   = BTN_NEXT;
    mode_d  = BTN_MODE;
    case (state_q)
      MANUAL: begin
        adv = nxt_edge;
        if (mode_edge) begin
          state_d = AUTO_RUN;
          dwell_d = '0;
          hold_d  = '0;
        end
      end
      AUTO_RUN: begin
        if (mode_edge) begin
          adv     = nxt_edge;
          state_d = MANUAL;
          dwell_d = '0;
          hold_d  = '0;
        end else if (nxt_edge) begin
          adv     = 1'b1;
          state_d = AUTO_HOLD;
          dwell_d = '0;
          hold_d  = '0;
        end else if (SEC_TICK) begin
          if (dwell_q == CW'(DWELL - 1)) begin
            adv     = 1'b1;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + CW'(1);
          end
        end
      end
      AUTO_HOLD: begin
        if (mode_edge) begin
          adv     = nxt_edge;
          state_d = MANUAL;
          dwell_d = '0;
          hold_d  = '0;
        end else if (nxt_edge) begin
          adv    = 1'b1;
          hold_d = '0;
        end else if (SEC_TICK) begin
          if (hold_q == CW'(HOLD - 1)) begin
            state_d = AUTO_RUN;
            dwell_d = '0;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = MANUAL;
        dwell_d = '0;
        hold_d  = '0;
      end
    endcase

    city_d = city_q;
    if (adv) city_d = (city_q == 3'(N_CITY - 1)) ? 3'd0 : city_q + 3'd1;

    // Each change reloads the blank window, so BLANK covers the last change in a burst.
    if (adv)                   blank_cnt_d = BW'(BLANK_CYC);
    else if (blank_cnt_q != '0) blank_cnt_d = blank_cnt_q - BW'(1);
    else                       blank_cnt_d = '0;

    auto_d     = (state_d != MANUAL);
    hold_act_d = (state_d == AUTO_HOLD);
    sel_chg_d  = adv;
    blank_d    = (blank_cnt_d != '0);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= MANUAL;
      dwell_q     <= '0;
      hold_q      <= '0;
      blank_cnt_q <= '0;
      city_q      <= 3'd0;
      nxt_q       <= 1'b1;
      mode_q      <= 1'b1;
      auto_q      <= 1'b0;
      hold_act_q  <= 1'b0;
      sel_chg_q   <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      hold_q      <= hold_d;
      blank_cnt_q <= blank_cnt_d;
      city_q      <= city_d;
      nxt_q       <= nxt_d;
      mode_q      <= mode_d;
      auto_q      <= auto_d;
      hold_act_q  <= hold_act_d;
      sel_chg_q   <= sel_chg_d;
      blank_q     <= blank_d;
    end
  end

  assign CITY_SEL = city_q;
  assign AUTO     = auto_q;
  assign HOLD_ACT = hold_act_q;
  assign SEL_CHG  = sel_chg_q;
  assign BLANK    = blank_q;

endmodule

// File: tb/tb_world_city_sched.sv
// Bench for world_city_sched: scenario tasks with inline checks plus a SEL_CHG scoreboard.
module tb_world_city_sched;

  localparam int N_CITY = 4;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       SEC_TICK = 1'b0;
  logic       BTN_NEXT = 1'b0;
  logic       BTN_MODE = 1'b0;
  logic [2:0] CITY_SEL;
  logic       AUTO, HOLD_ACT, SEL_CHG, BLANK;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] exp_city = 3'd0;
  logic [2:0] sb[$];

  world_city_sched #(.N_CITY(N_CITY), .DWELL(5), .HOLD(10), .BLANK_CYC(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .SEC_TICK(SEC_TICK), .BTN_NEXT(BTN_NEXT),
    .BTN_MODE(BTN_MODE), .CITY_SEL(CITY_SEL), .AUTO(AUTO), .HOLD_ACT(HOLD_ACT),
    .SEL_CHG(SEL_CHG), .BLANK(BLANK)
  );

  always #5 CLK = ~CLK;

  // Every SEL_CHG pulse must match the next expected city pushed by the stimulus.
  always @(negedge CLK) begin
    if (SEL_CHG) begin
      logic [2:0] e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_sel_chg: got CITY_SEL=%0d, no change expected", CITY_SEL);
      end else begin
        e = sb.pop_front();
        if (CITY_SEL !== e) begin
          n_err++;
          $display("FAIL sb_city: got %0d, want %0d", CITY_SEL, e);
        end
      end
    end
  end

  function automatic logic [2:0] nxt_city(input logic [2:0] c);
    return (c == 3'(N_CITY - 1)) ? 3'd0 : c + 3'd1;
  endfunction

  task automatic expect_adv();
    exp_city = nxt_city(exp_city);
    sb.push_back(exp_city);
  endtask

  task automatic press_next();
    expect_adv();
    BTN_NEXT = 1'b1; @(negedge CLK);
    BTN_NEXT = 1'b0; @(negedge CLK);
  endtask

  task automatic press_mode();
    BTN_MODE = 1'b1; @(negedge CLK);
    BTN_MODE = 1'b0; @(negedge CLK);
  endtask

  task automatic tick();
    SEC_TICK = 1'b1; @(negedge CLK);
    SEC_TICK = 1'b0; @(negedge CLK);
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({CITY_SEL, AUTO, HOLD_ACT, SEL_CHG, BLANK} !== 7'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, want 0000000", {CITY_SEL, AUTO, HOLD_ACT, SEL_CHG, BLANK});
    end
    RESETN = 1'b1; exp_city = 3'd0;
    @(negedge CLK);
  endtask

  task automatic test_manual_step();
    for (int i = 0; i < 5; i++) begin
      expect_adv();
      BTN_NEXT = 1'b1; @(negedge CLK);
      n_cmp++;
      if (CITY_SEL !== exp_city || SEL_CHG !== 1'b1 || BLANK !== 1'b1) begin
        n_err++;
        $display("FAIL manual_step%0d: got city=%0d chg=%b blank=%b, want city=%0d chg=1 blank=1",
                 i, CITY_SEL, SEL_CHG, BLANK, exp_city);
      end
      BTN_NEXT = 1'b0; @(negedge CLK);
      n_cmp++;
      if (SEL_CHG !== 1'b0 || BLANK !== 1'b1) begin
        n_err++;
        $display("FAIL manual_blank2_%0d: got chg=%b blank=%b, want chg=0 blank=1", i, SEL_CHG, BLANK);
      end
      @(negedge CLK);
      n_cmp++;
      if (BLANK !== 1'b0 || AUTO !== 1'b0) begin
        n_err++;
        $display("FAIL manual_blank_end%0d: got blank=%b auto=%b, want 0 0", i, BLANK, AUTO);
      end
    end
  endtask

  task automatic test_auto_scan();
    BTN_MODE = 1'b1; @(negedge CLK);
    n_cmp++;
    if (AUTO !== 1'b1 || HOLD_ACT !== 1'b0) begin
      n_err++;
      $display("FAIL auto_enter: got auto=%b hold=%b, want 1 0", AUTO, HOLD_ACT);
    end
    BTN_MODE = 1'b0; @(negedge CLK);
    for (int t = 1; t <= 12; t++) begin
      if (t % 5 == 0) expect_adv();
      tick();
      n_cmp++;
      if (CITY_SEL !== exp_city) begin
        n_err++;
        $display("FAIL auto_scan_tick%0d: got %0d, want %0d", t, CITY_SEL, exp_city);
      end
    end
  endtask

  task automatic test_next_on_expiry();
    press_mode();
    press_mode();
    repeat (4) tick();
    expect_adv();
    SEC_TICK = 1'b1; BTN_NEXT = 1'b1; @(negedge CLK);
    n_cmp++;
    if (CITY_SEL !== exp_city || HOLD_ACT !== 1'b1 || AUTO !== 1'b1) begin
      n_err++;
      $display("FAIL expiry_next: got city=%0d hold=%b auto=%b, want city=%0d hold=1 auto=1",
               CITY_SEL, HOLD_ACT, AUTO, exp_city);
    end
    SEC_TICK = 1'b0; BTN_NEXT = 1'b0; @(negedge CLK);
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_cmp++;
      if (CITY_SEL !== exp_city || HOLD_ACT !== (t < 10) || AUTO !== 1'b1) begin
        n_err++;
        $display("FAIL hold_tick%0d: got city=%0d hold=%b auto=%b, want city=%0d hold=%b auto=1",
                 t, CITY_SEL, HOLD_ACT, AUTO, exp_city, (t < 10));
      end
    end
    for (int t = 1; t <= 5; t++) begin
      if (t == 5) expect_adv();
      tick();
      n_cmp++;
      if (CITY_SEL !== exp_city) begin
        n_err++;
        $display("FAIL resume_tick%0d: got %0d, want %0d", t, CITY_SEL, exp_city);
      end
    end
  endtask

  task automatic test_next_mode_same();
    press_mode();
    while (exp_city != 3'd3) press_next();
    expect_adv();
    BTN_NEXT = 1'b1; BTN_MODE = 1'b1; @(negedge CLK);
    n_cmp++;
    if (CITY_SEL !== 3'd0 || AUTO !== 1'b1 || HOLD_ACT !== 1'b0) begin
      n_err++;
      $display("FAIL next_mode: got city=%0d auto=%b hold=%b, want city=0 auto=1 hold=0",
               CITY_SEL, AUTO, HOLD_ACT);
    end
    BTN_NEXT = 1'b0; BTN_MODE = 1'b0; @(negedge CLK);
    for (int t = 1; t <= 5; t++) begin
      if (t == 5) expect_adv();
      tick();
      n_cmp++;
      if (CITY_SEL !== exp_city) begin
        n_err++;
        $display("FAIL next_mode_dwell%0d: got %0d, want %0d", t, CITY_SEL, exp_city);
      end
    end
  endtask

  task automatic test_btn_held_reset();
    RESETN = 1'b0; BTN_NEXT = 1'b1;
    repeat (2) @(negedge CLK);
    RESETN = 1'b1; exp_city = 3'd0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (CITY_SEL !== 3'd0 || BLANK !== 1'b0) begin
      n_err++;
      $display("FAIL held_through_reset: got city=%0d blank=%b, want 0 0", CITY_SEL, BLANK);
    end
    BTN_NEXT = 1'b0; @(negedge CLK);
    press_next();
    @(negedge CLK);
    n_cmp++;
    if (CITY_SEL !== 3'd1) begin
      n_err++;
      $display("FAIL held_release_press: got %0d, want 1", CITY_SEL);
    end
  endtask

  task automatic test_reset_in_hold();
    press_mode();
    expect_adv();
    BTN_NEXT = 1'b1; @(negedge CLK);
    BTN_NEXT = 1'b0;
    n_cmp++;
    if (HOLD_ACT !== 1'b1 || BLANK !== 1'b1) begin
      n_err++;
      $display("FAIL hold_pre_reset: got hold=%b blank=%b, want 1 1", HOLD_ACT, BLANK);
    end
    #2 RESETN = 1'b0;
    #1;
    n_cmp++;
    if ({CITY_SEL, AUTO, HOLD_ACT, SEL_CHG, BLANK} !== 7'd0) begin
      n_err++;
      $display("FAIL async_reset: got %b, want 0000000", {CITY_SEL, AUTO, HOLD_ACT, SEL_CHG, BLANK});
    end
    repeat (2) @(negedge CLK);
    RESETN = 1'b1; exp_city = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (CITY_SEL !== 3'd0 || AUTO !== 1'b0 || SEL_CHG !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset%0d: got city=%0d auto=%b chg=%b, want 0 0 0", i, CITY_SEL, AUTO, SEL_CHG);
      end
    end
    press_next();
    n_cmp++;
    if (CITY_SEL !== 3'd1 || AUTO !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_manual: got city=%0d auto=%b, want 1 0", CITY_SEL, AUTO);
    end
  endtask

  initial begin
    test_reset();
    test_manual_step();
    test_auto_scan();
    test_next_on_expiry();
    test_next_mode_same();
    test_btn_held_reset();
    test_reset_in_hold();
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected changes never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
